// File: rtl/spi_arb_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_arb_master
// Desc     : SPI master (mode 0, MSB first) shared by two byte requesters.
//            An arbiter picks one requester per frame. The frame runs
//            LEAD -> SHIFT (8 bits) -> TRAIL with chip select held low, and
//            the received MISO byte is reported with a one-cycle pulse.
// Config   : SPI_ARB_FIXED_PRIO_EN defined   -> requester 0 always wins.
//            SPI_ARB_FIXED_PRIO_EN undefined -> round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module spi_arb_master #(
   parameter int unsigned CLK_DIV = 2   // SCLK half-period in i_Clk cycles, 1..255
) (
   input  logic       i_Clk,
   input  logic       i_Rst,            // asynchronous, active-low

   input  logic       i_Req0_valid,
   input  logic [7:0] i_Req0_data,
   output logic       o_Req0_ready,

   input  logic       i_Req1_valid,
   input  logic [7:0] i_Req1_data,
   output logic       o_Req1_ready,

   output logic       o_Rx_valid,
   output logic [7:0] o_Rx_data,
   output logic       o_Rx_id,

   output logic       o_Sclk,
   output logic       o_Mosi,
   input  logic       i_Miso,
   output logic       o_Cs_n,
   output logic       o_Busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_TRAIL = 2'd3
   } state_t;

   // Last cycle index of one SCLK half-period (and of LEAD / TRAIL).
   localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);

   // Frame state
   state_t     state_q;
   logic [7:0] cnt_q;       // cycle counter within the current phase
   logic [2:0] bit_q;       // index of the bit currently on the wire
   logic [6:0] tx_q;        // remaining transmit bits, next bit in [6]
   logic [7:0] rx_sh_q;     // MISO bits collected so far
   logic       id_q;        // requester owning the frame in flight

   // Registered outputs
   logic       cs_n_q;
   logic       sclk_q;
   logic       mosi_q;
   logic       rx_valid_q;
   logic [7:0] rx_data_q;
   logic       rx_id_q;
   logic       busy_q;

   // Arbitration / handshake
   logic       w_grant0;
   logic       w_grant1;
   logic       w_open;      // a handshake may complete this cycle
   logic       w_hs;        // handshake completes this cycle
   logic [7:0] w_hs_data;   // byte of the requester being accepted

   // No acceptance while a frame runs, nor in the cycle that reports the
   // previous frame, which guarantees chip select stays high between frames.
   assign w_open = (state_q == ST_IDLE) && !rx_valid_q;

`ifdef SPI_ARB_FIXED_PRIO_EN
   // Requester 0 has absolute priority.
   assign w_grant0 = i_Req0_valid;
   assign w_grant1 = i_Req1_valid & ~i_Req0_valid;
`else
   logic last_q;            // requester granted at the most recent handshake

   // Contention goes to the requester that was not granted last.
   assign w_grant0 = i_Req0_valid & (~i_Req1_valid |  last_q);
   assign w_grant1 = i_Req1_valid & (~i_Req0_valid | ~last_q);

   // Remember the winner of each handshake; reset favours requester 0 next.
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         last_q <= 1'b1;
      end else if (w_hs) begin
         last_q <= w_grant1;
      end
   end
`endif

   assign o_Req0_ready = w_open & w_grant0;
   assign o_Req1_ready = w_open & w_grant1;
   assign w_hs         = o_Req0_ready | o_Req1_ready;
   assign w_hs_data    = o_Req1_ready ? i_Req1_data : i_Req0_data;

   // Frame sequencer: accepts a byte, drives CS/SCLK/MOSI, collects MISO.
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 8'd0;
         bit_q      <= 3'd0;
         tx_q       <= 7'd0;
         rx_sh_q    <= 8'd0;
         id_q       <= 1'b0;
         cs_n_q     <= 1'b1;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= 8'd0;
         rx_id_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (w_hs) begin
                  // Select the slave and present the MSB immediately.
                  state_q <= ST_LEAD;
                  cs_n_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  mosi_q  <= w_hs_data[7];
                  tx_q    <= w_hs_data[6:0];
                  id_q    <= o_Req1_ready;
                  cnt_q   <= 8'd0;
                  bit_q   <= 3'd0;
               end
            end

            ST_LEAD: begin
               // Setup time between CS falling and the first SCLK low phase.
               if (cnt_q == c_DIV_LAST) begin
                  cnt_q   <= 8'd0;
                  state_q <= ST_SHIFT;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end

            ST_SHIFT: begin
               if (cnt_q != c_DIV_LAST) begin
                  cnt_q <= cnt_q + 8'd1;
               end else begin
                  cnt_q <= 8'd0;
                  if (!sclk_q) begin
                     // Rising edge: capture the slave's bit.
                     sclk_q  <= 1'b1;
                     rx_sh_q <= {rx_sh_q[6:0], i_Miso};
                  end else begin
                     // Falling edge: advance MOSI, or finish after bit 0.
                     sclk_q <= 1'b0;
                     if (bit_q == 3'd7) begin
                        state_q <= ST_TRAIL;
                     end else begin
                        bit_q  <= bit_q + 3'd1;
                        mosi_q <= tx_q[6];
                        tx_q   <= {tx_q[5:0], 1'b0};
                     end
                  end
               end
            end

            ST_TRAIL: begin
               // Hold time after the last falling edge, then release the slave.
               if (cnt_q == c_DIV_LAST) begin
                  cnt_q      <= 8'd0;
                  state_q    <= ST_IDLE;
                  cs_n_q     <= 1'b1;
                  mosi_q     <= 1'b0;
                  busy_q     <= 1'b0;
                  rx_valid_q <= 1'b1;
                  rx_data_q  <= rx_sh_q;
                  rx_id_q    <= id_q;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_Cs_n     = cs_n_q;
   assign o_Sclk     = sclk_q;
   assign o_Mosi     = mosi_q;
   assign o_Rx_valid = rx_valid_q;
   assign o_Rx_data  = rx_data_q;
   assign o_Rx_id    = rx_id_q;
   assign o_Busy     = busy_q;

endmodule
`default_nettype wire

// File: doc/spi_arb_master.md
SPI_ARB_MASTER -- requirements
Module: spi_arb_master

Interface
REQ-001 Parameter CLK_DIV, default 2, SCLK half-period in i_Clk cycles; legal range 1..255.
REQ-002 i_Clk  input  1  system clock; all logic on rising edge.
REQ-003 i_Rst  input  1  reset, asynchronous, active-low.
REQ-004 i_Req0_valid  input  1  requester 0 holds a byte to send.
REQ-005 i_Req0_data  input  8  requester 0 transmit byte.
REQ-006 o_Req0_ready  output  1  requester 0 byte accepted this cycle when valid.
REQ-007 i_Req1_valid, i_Req1_data, o_Req1_ready  as REQ-004..006, for requester 1.
REQ-008 o_Rx_valid  output  1  one-cycle pulse, received byte available.
REQ-009 o_Rx_data  output  8  received MISO byte.
REQ-010 o_Rx_id  output  1  requester owning the completed frame.
REQ-011 o_Sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-012 o_Mosi  output  1  SPI data out, MSB first.
REQ-013 i_Miso  input  1  SPI data in, MSB first.
REQ-014 o_Cs_n  output  1  slave select, active-low.
REQ-015 o_Busy  output  1  high whenever state is not IDLE.

Function
REQ-016 States SHALL be IDLE, LEAD, SHIFT, TRAIL; all outputs registered except o_ReqN_ready.
REQ-017 IDLE: o_Cs_n=1, o_Sclk=0; o_ReqN_ready SHALL be high only for the arbiter-selected requester, combinationally, only in IDLE.
REQ-018 Handshake valid&ready SHALL latch data and requester id, and move to LEAD next cycle; o_Cs_n low, o_Mosi=bit7 from that cycle.
REQ-019 Valid withdrawn before ready SHALL cause no transfer; requesters hold data stable while valid.
REQ-020 LEAD SHALL last CLK_DIV cycles with o_Sclk=0, then enter SHIFT.
REQ-021 SHIFT: 8 bits, each o_Sclk low CLK_DIV cycles then high CLK_DIV cycles; i_Miso sampled in the cycle o_Sclk goes 0->1; o_Mosi advances to the next bit when o_Sclk goes 1->0.
REQ-022 After the 8th high phase o_Sclk SHALL return to 0 and TRAIL SHALL hold o_Cs_n low for CLK_DIV cycles.
REQ-023 o_Cs_n low duration per frame SHALL be exactly 18*CLK_DIV cycles.
REQ-024 First cycle after TRAIL: o_Cs_n=1, state IDLE, o_Rx_valid=1 for one cycle with o_Rx_data and o_Rx_id; o_Rx_data holds until the next frame ends.
REQ-025 No handshake SHALL complete in the o_Rx_valid cycle; o_Cs_n stays high at least 1 cycle between frames.
REQ-026 Round-robin: single valid requester wins; both valid -> requester not granted last wins; last-granted pointer updates only on handshake.
REQ-027 o_Mosi SHALL be 0 whenever o_Cs_n=1.

Reset
REQ-028 Reset SHALL immediately force IDLE, o_Cs_n=1, o_Sclk=0, o_Mosi=0, o_Rx_valid=0, o_Rx_data=0, o_Rx_id=0, o_Busy=0, last-granted pointer=1.
REQ-029 Reset mid-frame SHALL discard the frame; no o_Rx_valid after release.
REQ-030 First arbitration after reset with both requesters valid SHALL grant requester 0.

Configuration
REQ-031 Macro SPI_ARB_FIXED_PRIO_EN defined: requester 0 always wins over requester 1, pointer unused.
REQ-032 SPI_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-026.

Verification
REQ-033 CLK_DIV=2, Req0 sends 0xA5, MISO slave returns 0x3C -> MOSI bits 1,0,1,0,0,1,0,1; o_Cs_n low 36 cycles; o_Rx_valid with o_Rx_data=0x3C, o_Rx_id=0.
REQ-034 Both valid continuously, Req0=0x11, Req1=0x22, round-robin -> frames ordered 0,1,0,1; o_Rx_id alternates.
REQ-035 Same stimulus with SPI_ARB_FIXED_PRIO_EN -> only requester 0 served while it stays valid.
REQ-036 CLK_DIV=1, 0xFF sent, MISO tied 0 -> o_Sclk toggles every cycle, 8 rising edges, o_Cs_n low 18 cycles, o_Rx_data=0x00.
REQ-037 i_Rst low at 4th SCLK rise -> o_Cs_n=1, o_Sclk=0 same cycle; no o_Rx_valid; next request starts clean frame.
REQ-038 Req1 valid raised during Req0 frame -> o_Req1_ready stays 0 until IDLE, Req1 served in the following frame.
